// File: rtl/conv_tile_scheduler_if.sv
// Handshake and data bundle between the tile scheduler, the PE, the input
// interface and the downstream tile consumer.
interface conv_tile_scheduler_if #(
    parameter int unsigned OUT_W = 116,
    parameter int unsigned CW    = 2
);
    logic             i_enable;
    logic             i_tile_ready;
    logic             o_pe_start;
    logic             i_pe_done;
    logic [OUT_W-1:0] i_pe_data;
    logic             o_proc_finish;
    logic [OUT_W-1:0] o_tile_data;
    logic             o_tile_valid;
    logic             i_tile_accept;
    logic [CW-1:0]    o_tile_row;
    logic [CW-1:0]    o_tile_col;
    logic             o_frame_done;
    logic             o_busy;
    logic             o_protocol_err;

    // Scheduler view
    modport master (
        input  i_enable, i_tile_ready, i_pe_done, i_pe_data, i_tile_accept,
        output o_pe_start, o_proc_finish, o_tile_data, o_tile_valid,
               o_tile_row, o_tile_col, o_frame_done, o_busy, o_protocol_err
    );

    // Surrounding logic view
    modport slave (
        output i_enable, i_tile_ready, i_pe_done, i_pe_data, i_tile_accept,
        input  o_pe_start, o_proc_finish, o_tile_data, o_tile_valid,
               o_tile_row, o_tile_col, o_frame_done, o_busy, o_protocol_err
    );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Sequences one convolution frame: launches the PE per ready input tile,
// captures its flattened output, hands it downstream and returns proc_finish
// to the input interface while tracking the tile row/column position.
module conv_tile_scheduler #(
    parameter int unsigned KERNEL_SIZE        = 3,
    parameter int unsigned INPUT_IMAGE_WIDTH  = 10,
    parameter int unsigned INPUT_IMAGE_HEIGHT = 10,
    parameter int unsigned INPUT_TILE_SIZE    = 4,
    parameter int unsigned INPUT_DATA_WIDTH   = 8,
    parameter int unsigned KERNEL_DATA_WIDTH  = 8
) (
    input logic                   clk,
    input logic                   reset,
    conv_tile_scheduler_if.master bus
);
    localparam int unsigned STRIDE = INPUT_TILE_SIZE - KERNEL_SIZE + 1;
    localparam int unsigned OUT_W  = STRIDE * STRIDE * (KERNEL_DATA_WIDTH + INPUT_DATA_WIDTH + 13);
    localparam int unsigned TX     = (INPUT_IMAGE_WIDTH - INPUT_TILE_SIZE) / STRIDE + 1;
    localparam int unsigned TY     = (INPUT_IMAGE_HEIGHT - INPUT_TILE_SIZE) / STRIDE + 1;
    localparam int unsigned TMAX   = (TX > TY) ? TX : TY;
    localparam int unsigned CW     = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;

    // Tiles must cover the image exactly with the derived stride
    generate
        if ((INPUT_TILE_SIZE > INPUT_IMAGE_WIDTH) || (INPUT_TILE_SIZE > INPUT_IMAGE_HEIGHT) ||
            (((INPUT_IMAGE_WIDTH - INPUT_TILE_SIZE) % STRIDE) != 0) ||
            (((INPUT_IMAGE_HEIGHT - INPUT_TILE_SIZE) % STRIDE) != 0)) begin : g_bad_geometry
            $error("conv_tile_scheduler: image size not tileable with stride %0d", STRIDE);
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        COMPUTE,
        HOLD,
        RELEASE,
        WAIT_DROP
    } state_t;

    state_t           state;
    logic             pe_start_q;
    logic             proc_finish_q;
    logic [OUT_W-1:0] tile_data_q;
    logic             tile_valid_q;
    logic [CW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             frame_done_q;
    logic             busy_q;
    logic             err_q;

    logic last_col;
    logic last_row;
    logic in_tile;

    assign last_col = (col_q == CW'(TX - 1));
    assign last_row = (row_q == CW'(TY - 1));
    assign in_tile  = (state == LAUNCH) || (state == COMPUTE) || (state == HOLD);

    // Tile sequencing FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pe_start_q    <= 1'b0;
            proc_finish_q <= 1'b0;
            tile_data_q   <= '0;
            tile_valid_q  <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            pe_start_q    <= 1'b0;
            proc_finish_q <= 1'b0;
            frame_done_q  <= 1'b0;

            // PE completion outside COMPUTE or ready vanishing mid-tile is illegal
            if ((bus.i_pe_done && (state != COMPUTE)) || (!bus.i_tile_ready && in_tile)) begin
                err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.i_enable && bus.i_tile_ready) begin
                        state      <= LAUNCH;
                        pe_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    if (bus.i_pe_done) begin
                        tile_data_q  <= bus.i_pe_data;
                        tile_valid_q <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.i_tile_accept) begin
                        tile_valid_q  <= 1'b0;
                        proc_finish_q <= 1'b1;
                        state         <= RELEASE;
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q        <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                row_q <= row_q + CW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    // A ready left over from the finished tile must not relaunch
                    if (!bus.i_tile_ready) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pe_start     = pe_start_q;
    assign bus.o_proc_finish  = proc_finish_q;
    assign bus.o_tile_data    = tile_data_q;
    assign bus.o_tile_valid   = tile_valid_q;
    assign bus.o_tile_row     = row_q;
    assign bus.o_tile_col     = col_q;
    assign bus.o_frame_done   = frame_done_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_protocol_err = err_q;
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: outputs are sampled and inputs
// driven on the falling clock edge.
module tb_conv_tile_scheduler;
    localparam int unsigned OUT_W = 116;
    localparam int unsigned CW    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    conv_tile_scheduler_if #(.OUT_W(OUT_W), .CW(CW)) bus ();

    conv_tile_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_enable      = 1'b0;
        bus.i_tile_ready  = 1'b0;
        bus.i_pe_done     = 1'b0;
        bus.i_pe_data     = '0;
        bus.i_tile_accept = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] ctrl;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_enable      = 1'($urandom);
            bus.i_tile_ready  = 1'($urandom);
            bus.i_pe_done     = 1'($urandom);
            bus.i_tile_accept = 1'($urandom);
            bus.i_pe_data     = OUT_W'({$urandom, $urandom, $urandom, $urandom});
            step();
            ctrl = {bus.o_pe_start, bus.o_proc_finish, bus.o_tile_valid, bus.o_frame_done,
                    bus.o_busy, bus.o_protocol_err, bus.o_tile_row, bus.o_tile_col};
            total++;
            if (ctrl !== 10'd0) begin
                bad++;
                $display("FAIL reset_ctrl cycle %0d: got %b want 0000000000", i, ctrl);
            end
            total++;
            if (bus.o_tile_data !== OUT_W'(0)) begin
                bad++;
                $display("FAIL reset_data cycle %0d: got %h want 0", i, bus.o_tile_data);
            end
        end
        idle_inputs();
        bus.i_enable     = 1'b1;
        bus.i_tile_ready = 1'b1;
        reset            = 1'b1;
        step();
        total++;
        if (bus.o_pe_start !== 1'b1 || bus.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_launch: got start=%b busy=%b want 1 1", bus.o_pe_start, bus.o_busy);
        end
        step();
        total++;
        if (bus.o_pe_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_launch_pulse: got start=%b want 0", bus.o_pe_start);
        end
    endtask

    task automatic test_single_tile();
        step();
        total++;
        if (bus.o_tile_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_compute_valid: got %b want 0", bus.o_tile_valid);
        end
        bus.i_pe_done = 1'b1;
        bus.i_pe_data = OUT_W'(116'h1234);
        step();
        total++;
        if (bus.o_tile_valid !== 1'b1 || bus.o_tile_data !== OUT_W'(116'h1234)) begin
            bad++;
            $display("FAIL single_capture: got valid=%b data=%h want 1 1234", bus.o_tile_valid, bus.o_tile_data);
        end
        bus.i_pe_done = 1'b0;
        bus.i_pe_data = OUT_W'(116'hDEAD);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.o_tile_valid !== 1'b1 || bus.o_tile_data !== OUT_W'(116'h1234) ||
                bus.o_proc_finish !== 1'b0 || bus.o_tile_row !== 2'd0 || bus.o_tile_col !== 2'd0) begin
                bad++;
                $display("FAIL single_hold stall %0d: got valid=%b data=%h fin=%b rc=%0d,%0d want 1 1234 0 0,0",
                         i, bus.o_tile_valid, bus.o_tile_data, bus.o_proc_finish, bus.o_tile_row, bus.o_tile_col);
            end
        end
        bus.i_tile_accept = 1'b1;
        step();
        total++;
        if (bus.o_tile_valid !== 1'b0 || bus.o_proc_finish !== 1'b1 ||
            bus.o_tile_row !== 2'd0 || bus.o_tile_col !== 2'd1 || bus.o_frame_done !== 1'b0) begin
            bad++;
            $display("FAIL single_release: got valid=%b fin=%b rc=%0d,%0d fd=%b want 0 1 0,1 0",
                     bus.o_tile_valid, bus.o_proc_finish, bus.o_tile_row, bus.o_tile_col, bus.o_frame_done);
        end
        bus.i_tile_accept = 1'b0;
        step();
        total++;
        if (bus.o_proc_finish !== 1'b0 || bus.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_wait_drop: got fin=%b busy=%b want 0 1", bus.o_proc_finish, bus.o_busy);
        end
        bus.i_tile_ready = 1'b0;
        step();
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got busy=%b err=%b want 0 0", bus.o_busy, bus.o_protocol_err);
        end
    endtask

    task automatic test_full_frame();
        int               fd_count;
        int               nt;
        logic [OUT_W-1:0] d;
        fd_count = 0;
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.i_tile_accept = 1'b1;
        for (int t = 0; t < 16; t++) begin
            nt = (t + 1) % 16;
            d  = OUT_W'({$urandom, $urandom, $urandom, $urandom});
            total++;
            if (bus.o_tile_row !== CW'(t / 4) || bus.o_tile_col !== CW'(t % 4) || bus.o_busy !== 1'b0) begin
                bad++;
                $display("FAIL frame_pos tile %0d: got rc=%0d,%0d busy=%b want %0d,%0d 0",
                         t, bus.o_tile_row, bus.o_tile_col, bus.o_busy, t / 4, t % 4);
            end
            bus.i_tile_ready = 1'b1;
            bus.i_enable     = 1'b1;
            step();
            total++;
            if (bus.o_pe_start !== 1'b1) begin
                bad++;
                $display("FAIL frame_start tile %0d: got %b want 1", t, bus.o_pe_start);
            end
            step();
            bus.i_pe_done = 1'b1;
            bus.i_pe_data = d;
            step();
            total++;
            if (bus.o_tile_valid !== 1'b1 || bus.o_tile_data !== d) begin
                bad++;
                $display("FAIL frame_data tile %0d: got valid=%b data=%h want 1 %h", t, bus.o_tile_valid, bus.o_tile_data, d);
            end
            bus.i_pe_done = 1'b0;
            step();
            if (bus.o_frame_done === 1'b1) fd_count++;
            total++;
            if (bus.o_proc_finish !== 1'b1 || bus.o_frame_done !== (t == 15) ||
                bus.o_tile_row !== CW'(nt / 4) || bus.o_tile_col !== CW'(nt % 4)) begin
                bad++;
                $display("FAIL frame_release tile %0d: got fin=%b fd=%b rc=%0d,%0d want 1 %0d %0d,%0d",
                         t, bus.o_proc_finish, bus.o_frame_done, bus.o_tile_row, bus.o_tile_col,
                         (t == 15), nt / 4, nt % 4);
            end
            bus.i_tile_ready = 1'b0;
            step();
            total++;
            if (bus.o_proc_finish !== 1'b0 || bus.o_frame_done !== 1'b0) begin
                bad++;
                $display("FAIL frame_pulse_width tile %0d: got fin=%b fd=%b want 0 0", t, bus.o_proc_finish, bus.o_frame_done);
            end
            step();
        end
        total++;
        if (fd_count != 1 || bus.o_protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL frame_done_count: got %0d err=%b want 1 0", fd_count, bus.o_protocol_err);
        end
    endtask

    task automatic test_stale_ready();
        bus.i_tile_accept = 1'b1;
        bus.i_enable      = 1'b1;
        bus.i_tile_ready  = 1'b1;
        step();
        step();
        bus.i_pe_done = 1'b1;
        bus.i_pe_data = OUT_W'(116'h55);
        step();
        bus.i_pe_done = 1'b0;
        step();
        total++;
        if (bus.o_proc_finish !== 1'b1) begin
            bad++;
            $display("FAIL stale_finish: got %b want 1", bus.o_proc_finish);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (bus.o_pe_start !== 1'b0 || bus.o_busy !== 1'b1) begin
                bad++;
                $display("FAIL stale_no_relaunch cycle %0d: got start=%b busy=%b want 0 1", i, bus.o_pe_start, bus.o_busy);
            end
        end
        bus.i_tile_ready = 1'b0;
        step();
        total++;
        if (bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL stale_drop_idle: got busy=%b want 0", bus.o_busy);
        end
        bus.i_tile_ready = 1'b1;
        step();
        total++;
        if (bus.o_pe_start !== 1'b1) begin
            bad++;
            $display("FAIL stale_relaunch: got start=%b want 1", bus.o_pe_start);
        end
        step();
        bus.i_pe_done = 1'b1;
        step();
        bus.i_pe_done = 1'b0;
        step();
        bus.i_tile_ready = 1'b0;
        step();
        step();
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_tile_row !== 2'd0 || bus.o_tile_col !== 2'd2) begin
            bad++;
            $display("FAIL stale_end: got busy=%b rc=%0d,%0d want 0 0,2", bus.o_busy, bus.o_tile_row, bus.o_tile_col);
        end
    endtask

    task automatic test_protocol();
        bus.i_tile_accept = 1'b1;
        bus.i_enable      = 1'b0;
        step();
        total++;
        if (bus.o_protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL proto_accept_idle: got err=%b want 0", bus.o_protocol_err);
        end
        bus.i_pe_done = 1'b1;
        bus.i_pe_data = OUT_W'(116'hBEEF);
        step();
        total++;
        if (bus.o_protocol_err !== 1'b1 || bus.o_tile_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL proto_stray_done: got err=%b valid=%b busy=%b want 1 0 0",
                     bus.o_protocol_err, bus.o_tile_valid, bus.o_busy);
        end
        bus.i_pe_done = 1'b0;
        step();
        step();
        step();
        total++;
        if (bus.o_protocol_err !== 1'b1 || bus.o_tile_data === OUT_W'(116'hBEEF)) begin
            bad++;
            $display("FAIL proto_sticky: got err=%b data=%h want 1 (not beef)", bus.o_protocol_err, bus.o_tile_data);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        total++;
        if (bus.o_protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL proto_reset_clear: got err=%b want 0", bus.o_protocol_err);
        end
        bus.i_enable     = 1'b1;
        bus.i_tile_ready = 1'b1;
        step();
        bus.i_tile_ready = 1'b0;
        step();
        total++;
        if (bus.o_protocol_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_ready_drop: got err=%b want 1", bus.o_protocol_err);
        end
        bus.i_pe_done = 1'b1;
        bus.i_pe_data = OUT_W'(116'h77);
        step();
        bus.i_pe_done = 1'b0;
        total++;
        if (bus.o_tile_valid !== 1'b1 || bus.o_tile_data !== OUT_W'(116'h77)) begin
            bad++;
            $display("FAIL proto_completes: got valid=%b data=%h want 1 77", bus.o_tile_valid, bus.o_tile_data);
        end
        step();
        total++;
        if (bus.o_proc_finish !== 1'b1 || bus.o_tile_col !== 2'd1) begin
            bad++;
            $display("FAIL proto_finish: got fin=%b col=%0d want 1 1", bus.o_proc_finish, bus.o_tile_col);
        end
        step();
        step();
    endtask

    task automatic test_gating_reset();
        bus.i_enable      = 1'b0;
        bus.i_tile_ready  = 1'b1;
        bus.i_tile_accept = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (bus.o_pe_start !== 1'b0 || bus.o_busy !== 1'b0) begin
                bad++;
                $display("FAIL gate_no_launch cycle %0d: got start=%b busy=%b want 0 0", i, bus.o_pe_start, bus.o_busy);
            end
        end
        bus.i_enable = 1'b1;
        step();
        total++;
        if (bus.o_pe_start !== 1'b1) begin
            bad++;
            $display("FAIL gate_launch: got start=%b want 1", bus.o_pe_start);
        end
        bus.i_enable = 1'b0;
        step();
        bus.i_pe_done = 1'b1;
        bus.i_pe_data = OUT_W'(116'h9);
        step();
        bus.i_pe_done = 1'b0;
        step();
        total++;
        if (bus.o_proc_finish !== 1'b1 || bus.o_tile_row !== 2'd0 || bus.o_tile_col !== 2'd2) begin
            bad++;
            $display("FAIL gate_enable_midtile: got fin=%b rc=%0d,%0d want 1 0,2",
                     bus.o_proc_finish, bus.o_tile_row, bus.o_tile_col);
        end
        bus.i_tile_ready = 1'b0;
        step();
        step();
        bus.i_enable      = 1'b1;
        bus.i_tile_ready  = 1'b1;
        bus.i_tile_accept = 1'b0;
        step();
        step();
        bus.i_pe_done = 1'b1;
        bus.i_pe_data = OUT_W'(116'hA5);
        step();
        bus.i_pe_done = 1'b0;
        step();
        total++;
        if (bus.o_tile_valid !== 1'b1 || bus.o_tile_data !== OUT_W'(116'hA5)) begin
            bad++;
            $display("FAIL gate_hold: got valid=%b data=%h want 1 a5", bus.o_tile_valid, bus.o_tile_data);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.o_tile_valid !== 1'b0 || bus.o_tile_row !== 2'd0 || bus.o_tile_col !== 2'd0 ||
            bus.o_busy !== 1'b0 || bus.o_tile_data !== OUT_W'(0)) begin
            bad++;
            $display("FAIL gate_async_reset: got valid=%b rc=%0d,%0d busy=%b data=%h want 0 0,0 0 0",
                     bus.o_tile_valid, bus.o_tile_row, bus.o_tile_col, bus.o_busy, bus.o_tile_data);
        end
        idle_inputs();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_tile();
        test_full_frame();
        test_stale_ready();
        test_protocol();
        test_gating_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
